path_dispatch: RTL and testbench
================================

Name: path_dispatch

Overview:
- Stage directly downstream of the pathID lookup. Buffers packet words while the lookup resolves.
- Pairs each packet, in arrival order, with the next pathID result from the lookup. Forwards the whole packet to one of N_PORT egress ports, or drops it on a miss.
- Sits between the firewall match/lookup pipeline and the egress port queues.

Parameters:
- w_pkt, 134, packet word width; [133:132] = 01 head, 11 body, 10 tail.
- N_PORT, 4, number of egress ports.
- d_pkt, 8, log2 depth of the data FIFO (256 words).
- d_path, 4, log2 depth of the pathID FIFO (16 entries).
- MAX_PKT, 96, maximum packet length in words; sets the input admission threshold.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- pktin_data_wr  in  1  packet word strobe.
- pktin_data  in  w_pkt  packet word.
- pktin_ready  out  1  high = room for one more maximum-length packet.
- pathID_valid  in  1  one pulse per packet, in packet order.
- pathID  in  18  path result; 0 = miss/drop; [1:0] = egress port.
- pktout_data_wr  out  N_PORT  one-hot write strobe to the selected port.
- pktout_data  out  w_pkt  shared egress data bus.
- pktout_ready  in  N_PORT  per-port ready; sampled only at packet start.

Behaviour:
- Reset values: all outputs 0 except pktin_ready=1. Both FIFOs flushed; FSM goes to IDLE. Reset mid-packet discards all buffered words and pathIDs with no partial output.
- Data FIFO and pathID FIFO are show-ahead: dout is valid whenever the FIFO is not empty. Writes happen unconditionally on the strobes.
- Admission: pktin_ready is registered.
  - pktin_ready = (free data words >= MAX_PKT) AND (pathID FIFO free entries >= 2).
  - Upstream may start a new packet only while pktin_ready=1.
  - Upstream must always complete a packet it has started.
- Overflow: a write to a full FIFO is dropped and sets internal sticky flag ovf. ovf is cleared only by reset. A compliant source never triggers it.
- FSM states:
  - IDLE
    - Data FIFO not empty and head word is not a head (!=01): pop it (resync discard), stay in IDLE.
    - Data head word = 01 and pathID FIFO not empty: pop the pathID, latch it into path_r, go to CHECK.
  - CHECK
    - path_r == 0: go to DROP.
    - pktout_ready[path_r[1:0]] == 1: go to SEND.
    - Otherwise: stay in CHECK, with no timeout.
  - SEND
    - Each cycle the data FIFO is not empty: pop one word; drive pktout_data with it and pktout_data_wr = one-hot(path_r[1:0]) on the next cycle (registered).
    - When the popped word is a tail (10): go to IDLE.
    - Data FIFO empty mid-packet: stall with strobe 0 and hold pktout_data.
    - pktout_ready deasserting mid-packet is ignored.
  - DROP
    - Pop words with no output. On the tail word, go to IDLE.
- Latency: with both FIFOs holding data and the port ready, the head word appears on pktout 3 cycles after the IDLE decision cycle.
  - The IDLE decision happens at the earliest 1 cycle after the head is written.
  - Body words then stream at 1 word/cycle.
- Packet pipelining: at most one packet is in flight. The next IDLE evaluation starts the cycle after the tail is popped.
- pathID[17:2] is opaque to this block and is not decoded further.
- Simultaneous events: FIFO write and read in the same cycle are both honoured; occupancy is unchanged.
- Minimum packet is 2 words (head + tail).

Optional Feature:
- Macro PATH_DISPATCH_CNT_EN.
- Defined:
  - Adds outputs cnt_fwd[31:0], cnt_drop[31:0], cnt_discard[31:0] and ovf_flag[0:0], all reset to 0.
  - cnt_fwd increments on each forwarded tail.
  - cnt_drop increments on each DROP tail.
  - cnt_discard increments per resync-discarded word.
  - Counters wrap at 2^32.
- Undefined: these ports and counters are absent; ovf remains internal only. Dispatch behaviour is identical either way.

Test Plan:
- Forward path: 4-word packet, pathID=18'h00006, all ports ready -> 4 words on pktout with pktout_data_wr=4'b0100, data identical, head 3 cycles after decision.
- Miss: 3-word packet, pathID=0 -> no pktout_data_wr; FIFOs empty afterwards; cnt_drop=1 (with macro).
- Order and latency skew: three packets arrive before their pathIDs; pathIDs 1, 0, 3 then arrive 10 cycles later -> packet A to port 1, B dropped, C to port 3, in order.
- Port backpressure: pktout_ready=4'b1101, pathID=1 -> FSM holds in CHECK; raising ready[1] after 20 cycles -> packet sent intact; ready[1] dropped mid-packet -> transmission continues.
- Admission: fill with 2 words short of the 256-word capacity -> pktin_ready=0 once free < 96, and returns to 1 after drain.
- Resync and reset: a stray body word (11) at the FIFO head -> discarded, pathID not consumed, cnt_discard=1. Reset asserted mid-SEND -> all outputs 0, pktin_ready=1, no further words emitted.

Source files
------------

// File: rtl/path_dispatch.sv
// Pairs buffered packets with lookup pathIDs in arrival order; forwards each to one port or drops it.
// Define PATH_DISPATCH_CNT_EN to expose forward/drop/discard counters and the overflow flag.
module path_dispatch #(
  parameter int w_pkt   = 134,
  parameter int N_PORT  = 4,
  parameter int d_pkt   = 8,
  parameter int d_path  = 4,
  parameter int MAX_PKT = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pktin_data_wr,
  input  logic [w_pkt-1:0]  pktin_data,
  output logic              pktin_ready,
  input  logic              pathID_valid,
  input  logic [17:0]       pathID,
  output logic [N_PORT-1:0] pktout_data_wr,
  output logic [w_pkt-1:0]  pktout_data,
  input  logic [N_PORT-1:0] pktout_ready
`ifdef PATH_DISPATCH_CNT_EN
  ,
  output logic [31:0]       cnt_fwd,
  output logic [31:0]       cnt_drop,
  output logic [31:0]       cnt_discard,
  output logic [0:0]        ovf_flag
`endif
);
  localparam int DDEPTH = 1 << d_pkt;
  localparam int PDEPTH = 1 << d_path;
  localparam logic [1:0] T_HEAD = 2'b01;
  localparam logic [1:0] T_TAIL = 2'b10;

  typedef enum logic [1:0] {IDLE, CHECK, SEND, DROP} state_t;

  state_t            state_q;
  logic [17:0]       path_q;
  logic [N_PORT-1:0] wr_q;
  logic [w_pkt-1:0]  data_q;
  logic              ready_q;
  logic              ovf_q;

  logic [w_pkt-1:0]  dmem [DDEPTH];
  logic [d_pkt-1:0]  dwp_q, drp_q;
  logic [d_pkt:0]    dcnt_q, dcnt_d;
  logic              dempty, dfull, dwr_en, drd_en;
  logic [w_pkt-1:0]  ddout;
  logic [1:0]        dtype;

  logic [17:0]       pmem [PDEPTH];
  logic [d_path-1:0] pwp_q, prp_q;
  logic [d_path:0]   pcnt_q, pcnt_d;
  logic              pempty, pfull, pwr_en, prd_en;
  logic [17:0]       pdout;

  logic [N_PORT-1:0] port_sel;
  logic              port_rdy;

  // Both FIFOs are show-ahead: the word at the read pointer is visible while not empty.
  assign dempty = (dcnt_q == '0);
  assign dfull  = (dcnt_q == (d_pkt+1)'(DDEPTH));
  assign dwr_en = pktin_data_wr && (!dfull || drd_en);
  assign ddout  = dmem[drp_q];
  assign dtype  = ddout[w_pkt-1 -: 2];
  assign dcnt_d = dcnt_q + (d_pkt+1)'(dwr_en) - (d_pkt+1)'(drd_en);

  assign pempty = (pcnt_q == '0);
  assign pfull  = (pcnt_q == (d_path+1)'(PDEPTH));
  assign pwr_en = pathID_valid && (!pfull || prd_en);
  assign pdout  = pmem[prp_q];
  assign pcnt_d = pcnt_q + (d_path+1)'(pwr_en) - (d_path+1)'(prd_en);

  genvar gi;
  for (gi = 0; gi < N_PORT; gi++) begin : g_sel
    assign port_sel[gi] = (path_q[1:0] == 2'(gi));
  end
  assign port_rdy = |(pktout_ready & port_sel);

  always_ff @(posedge clk) begin
    if (dwr_en) dmem[dwp_q] <= pktin_data;
  end

  always_ff @(posedge clk) begin
    if (pwr_en) pmem[pwp_q] <= pathID;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwp_q   <= '0;
      drp_q   <= '0;
      dcnt_q  <= '0;
      pwp_q   <= '0;
      prp_q   <= '0;
      pcnt_q  <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      if (dwr_en) dwp_q <= dwp_q + d_pkt'(1);
      if (drd_en) drp_q <= drp_q + d_pkt'(1);
      if (pwr_en) pwp_q <= pwp_q + d_path'(1);
      if (prd_en) prp_q <= prp_q + d_path'(1);
      dcnt_q <= dcnt_d;
      pcnt_q <= pcnt_d;
      if ((pktin_data_wr && !dwr_en) || (pathID_valid && !pwr_en)) ovf_q <= 1'b1;
      // Admit only while a full maximum-length packet and two more pathIDs still fit.
      ready_q <= (dcnt_d <= (d_pkt+1)'(DDEPTH - MAX_PKT)) &&
                 (pcnt_d <= (d_path+1)'(PDEPTH - 2));
    end
  end

  always_comb begin
    drd_en = 1'b0;
    prd_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!dempty) begin
          if (dtype != T_HEAD) drd_en = 1'b1;
          else if (!pempty)    prd_en = 1'b1;
        end
      end
      SEND, DROP: drd_en = !dempty;
      default: ;
    endcase
  end

`ifdef PATH_DISPATCH_CNT_EN
  logic [31:0] cnt_fwd_q, cnt_drop_q, cnt_discard_q;
  assign cnt_fwd     = cnt_fwd_q;
  assign cnt_drop    = cnt_drop_q;
  assign cnt_discard = cnt_discard_q;
  assign ovf_flag    = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      path_q  <= '0;
      wr_q    <= '0;
      data_q  <= '0;
`ifdef PATH_DISPATCH_CNT_EN
      cnt_fwd_q     <= '0;
      cnt_drop_q    <= '0;
      cnt_discard_q <= '0;
`endif
    end else begin
      wr_q <= '0;
      case (state_q)
        IDLE: begin
          if (prd_en) begin
            path_q  <= pdout;
            state_q <= CHECK;
          end
`ifdef PATH_DISPATCH_CNT_EN
          if (drd_en) cnt_discard_q <= cnt_discard_q + 32'd1;
`endif
        end
        CHECK: begin
          if (path_q == '0)  state_q <= DROP;
          else if (port_rdy) state_q <= SEND;
        end
        SEND: begin
          if (drd_en) begin
            wr_q   <= port_sel;
            data_q <= ddout;
            if (dtype == T_TAIL) begin
              state_q <= IDLE;
`ifdef PATH_DISPATCH_CNT_EN
              cnt_fwd_q <= cnt_fwd_q + 32'd1;
`endif
            end
          end
        end
        DROP: begin
          if (drd_en && dtype == T_TAIL) begin
            state_q <= IDLE;
`ifdef PATH_DISPATCH_CNT_EN
            cnt_drop_q <= cnt_drop_q + 32'd1;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pktout_data_wr = wr_q;
  assign pktout_data    = data_q;
  assign pktin_ready    = ready_q;

endmodule

// File: tb/tb_path_dispatch.sv
// Bench for path_dispatch: an in-order packet/pathID pairing model feeds a per-cycle output
// checker; directed scenarios add literal expectations on latency, ports and admission.
module tb_path_dispatch;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         pktin_data_wr = 1'b0;
  logic [133:0] pktin_data = '0;
  logic         pktin_ready;
  logic         pathID_valid = 1'b0;
  logic [17:0]  pathID = '0;
  logic [3:0]   pktout_data_wr;
  logic [133:0] pktout_data;
  logic [3:0]   pktout_ready = 4'hF;
`ifdef PATH_DISPATCH_CNT_EN
  logic [31:0]  cnt_fwd, cnt_drop, cnt_discard;
  logic [0:0]   ovf_flag;
`endif

  path_dispatch #(.w_pkt(134), .N_PORT(4), .d_pkt(8), .d_path(4), .MAX_PKT(96)) dut (
    .clk(clk), .reset(reset),
    .pktin_data_wr(pktin_data_wr), .pktin_data(pktin_data), .pktin_ready(pktin_ready),
    .pathID_valid(pathID_valid), .pathID(pathID),
    .pktout_data_wr(pktout_data_wr), .pktout_data(pktout_data), .pktout_ready(pktout_ready)
`ifdef PATH_DISPATCH_CNT_EN
    , .cnt_fwd(cnt_fwd), .cnt_drop(cnt_drop), .cnt_discard(cnt_discard), .ovf_flag(ovf_flag)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed { logic [3:0] strobe; logic [133:0] data; } exp_t;
  typedef struct { logic [3:0] s; logic [133:0] d; int c; } log_t;

  // Model: packets and pathIDs each queue in arrival order; the n-th packet takes the n-th pathID.
  logic [133:0] pend_words[$];
  int           pend_len[$];
  logic [17:0]  pend_pid[$];
  exp_t         exp_q[$];
  log_t         out_log[$];
  int           cur_left = 0;
  logic [17:0]  cur_pid = '0;
  logic [31:0]  seq = 32'h1000;
  int           head_cyc = 0;
  logic [133:0] head_word = '0;
  exp_t         e_cur;

  task automatic chk(input string nm, input logic [133:0] act, input logic [133:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    logic [133:0] w;
    forever begin
      if (cur_left == 0) begin
        if (pend_len.size() == 0 || pend_pid.size() == 0) return;
        cur_left = pend_len.pop_front();
        cur_pid  = pend_pid.pop_front();
      end
      if (pend_words.size() == 0) return;
      w = pend_words.pop_front();
      cur_left--;
      if (cur_pid != 18'd0) begin
        e.strobe = 4'b0001 << cur_pid[1:0];
        e.data   = w;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic model_clear();
    pend_words.delete(); pend_len.delete(); pend_pid.delete(); exp_q.delete();
    cur_left = 0;
  endtask

  always @(negedge clk) begin
    if (!reset && pktout_data_wr != 4'd0) begin
      out_log.push_back('{s: pktout_data_wr, d: pktout_data, c: cyc});
      if (exp_q.size() == 0) chk("unexpected_out", {130'd0, pktout_data_wr}, 134'd0);
      else begin
        e_cur = exp_q.pop_front();
        chk("out_strobe", {130'd0, pktout_data_wr}, {130'd0, e_cur.strobe});
        chk("out_data", pktout_data, e_cur.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [1:0] t, input bit m, input bit pid_en, input logic [17:0] pid);
    logic [133:0] w;
    seq = seq + 32'd1;
    w = {t, {4{seq}}, 4'h5};
    pktin_data_wr = 1'b1;
    pktin_data    = w;
    if (pid_en) begin
      pathID_valid = 1'b1;
      pathID       = pid;
      pend_pid.push_back(pid);
    end
    tick();
    pktin_data_wr = 1'b0;
    pathID_valid  = 1'b0;
    if (t == 2'b01) begin
      head_cyc  = cyc;
      head_word = w;
    end
    if (m) pend_words.push_back(w);
    model_step();
  endtask

  task automatic put_pid(input logic [17:0] pid);
    pathID_valid = 1'b1;
    pathID       = pid;
    tick();
    pathID_valid = 1'b0;
    pend_pid.push_back(pid);
    model_step();
  endtask

  task automatic send_pkt(input int len, input bit pid_en, input logic [17:0] pid);
    pend_len.push_back(len);
    for (int i = 0; i < len; i++)
      put_word(i == 0 ? 2'b01 : (i == len - 1 ? 2'b10 : 2'b11), 1'b1, pid_en && i == 0, pid);
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin tick(); k++; end
    chk(nm, exp_q.size(), 0);
    repeat (8) tick();
  endtask

  task automatic wait_out(input int n, input int budget, input string nm);
    int k = 0;
    while (out_log.size() < n && k < budget) begin tick(); k++; end
    chk(nm, out_log.size() >= n, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    model_clear();
    out_log.delete();
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    tick();
    chk("rst_wr", pktout_data_wr, 0);
    chk("rst_data", pktout_data, 0);
    chk("rst_ready", pktin_ready, 1);
    tick();
    reset = 1'b0;
    tick();

    // Forward: 4 words to port 2, head 3 cycles after the decision
    out_log.delete();
    send_pkt(4, 1'b1, 18'h00006);
    wait_drain(40, "fwd_drain");
    chk("fwd_count", out_log.size(), 4);
    chk("fwd_strobe", out_log[0].s, 4'b0100);
    chk("fwd_head_data", out_log[0].d, head_word);
    chk("fwd_latency", out_log[0].c - head_cyc, 3);
    chk("fwd_stream", out_log[3].c - out_log[0].c, 3);
`ifdef PATH_DISPATCH_CNT_EN
    chk("fwd_cnt", cnt_fwd, 1);
`endif

    // Miss: pathID 0 drops the packet
    out_log.delete();
    send_pkt(3, 1'b1, 18'h00000);
    wait_drain(40, "miss_drain");
    chk("miss_no_out", out_log.size(), 0);
    chk("miss_ready", pktin_ready, 1);
`ifdef PATH_DISPATCH_CNT_EN
    chk("miss_cnt", cnt_drop, 1);
`endif

    // Latency skew: three packets, pathIDs arrive later
    out_log.delete();
    send_pkt(2, 1'b0, 18'h0);
    send_pkt(3, 1'b0, 18'h0);
    send_pkt(4, 1'b0, 18'h0);
    repeat (10) tick();
    chk("skew_wait", out_log.size(), 0);
    put_pid(18'h00001);
    put_pid(18'h00000);
    put_pid(18'h00003);
    wait_drain(60, "skew_drain");
    chk("skew_count", out_log.size(), 6);
    chk("skew_a_port", out_log[1].s, 4'b0010);
    chk("skew_c_port", out_log[2].s, 4'b1000);
    chk("skew_c_tail", out_log[5].s, 4'b1000);
`ifdef PATH_DISPATCH_CNT_EN
    chk("skew_fwd_cnt", cnt_fwd, 3);
    chk("skew_drop_cnt", cnt_drop, 2);
`endif

    // Backpressure: port 1 not ready holds in CHECK, then mid-packet deassert ignored
    out_log.delete();
    pktout_ready = 4'b1101;
    send_pkt(5, 1'b1, 18'h00001);
    repeat (20) tick();
    chk("bp_hold", out_log.size(), 0);
    pktout_ready = 4'b1111;
    wait_out(1, 20, "bp_start");
    pktout_ready = 4'b1101;
    wait_drain(40, "bp_drain");
    chk("bp_count", out_log.size(), 5);
    chk("bp_port", out_log[4].s, 4'b0010);
    pktout_ready = 4'b1111;

    // Admission: 254 words with no pathID, then drain
    out_log.delete();
    pend_len.push_back(254);
    for (int n = 1; n <= 254; n++) begin
      put_word(n == 1 ? 2'b01 : (n == 254 ? 2'b10 : 2'b11), 1'b1, 1'b0, 18'h0);
      chk("adm_ready", pktin_ready, (256 - n) >= 96);
    end
    put_pid(18'h00002);
    wait_drain(400, "adm_drain");
    chk("adm_count", out_log.size(), 254);
    chk("adm_ready_back", pktin_ready, 1);

    // pathID admission: ready needs two free pathID entries
    for (int k = 1; k <= 15; k++) begin
      put_pid(18'h00001);
      chk("pid_ready", pktin_ready, (16 - k) >= 2);
    end
`ifdef PATH_DISPATCH_CNT_EN
    chk("ovf_clear", ovf_flag, 0);
`endif
    do_reset();
    chk("flush_ready", pktin_ready, 1);

    // Resync: stray body discarded, pathID kept for the next packet
    put_word(2'b11, 1'b0, 1'b1, 18'h00005);
    repeat (3) tick();
    send_pkt(2, 1'b0, 18'h0);
    wait_drain(40, "resync_drain");
    chk("resync_count", out_log.size(), 2);
    chk("resync_port", out_log[0].s, 4'b0010);
`ifdef PATH_DISPATCH_CNT_EN
    chk("resync_cnt", cnt_discard, 1);
`endif

    // Reset mid-SEND
    out_log.delete();
    pend_len.push_back(10);
    put_word(2'b01, 1'b1, 1'b1, 18'h00003);
    for (int i = 0; i < 3; i++) put_word(2'b11, 1'b1, 1'b0, 18'h0);
    wait_out(2, 20, "mid_start");
    reset = 1'b1;
    #1;
    chk("mid_rst_wr", pktout_data_wr, 0);
    chk("mid_rst_data", pktout_data, 0);
    chk("mid_rst_ready", pktin_ready, 1);
    tick(); tick();
    reset = 1'b0;
    model_clear();
    out_log.delete();
    repeat (15) tick();
    chk("mid_quiet", out_log.size(), 0);
    chk("mid_ready", pktin_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
